mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//   Shares one 2x2 combinational multiplier (lab3_3_2: ports a, b, out) between two requesters.
//   Arbitrates round-robin and captures the granted operands into registers.
//   Holds those operands on the multiplier for HOLD_CYCLES cycles, then registers the product.
//   Pulses a per-requester done. Sits between the switch/operand front-end and the LED result path.
// PARAMETERS
//   WIDTH        2   operand width; product width is 2*WIDTH (multiplier instance sized to match)
//   HOLD_CYCLES  1   settle cycles in CALC before sampling the product; legal range 1..15, 0 illegal
// PORTS
//   clk      in   1        rising-edge clock
//   reset    in   1        asynchronous, active-high reset
//   req0     in   1        requester 0 wants a product
//   a0       in   WIDTH    requester 0 operand a
//   b0       in   WIDTH    requester 0 operand b
//   req1     in   1        requester 1 wants a product
//   a1       in   WIDTH    requester 1 operand a
//   b1       in   WIDTH    requester 1 operand b
//   gnt0     out  1        requester 0 owns the multiplier (registered)
//   gnt1     out  1        requester 1 owns the multiplier (registered)
//   done0    out  1        one-cycle pulse: result valid for requester 0
//   done1    out  1        one-cycle pulse: result valid for requester 1
//   result   out  2*WIDTH  last completed product; held until the next completion
//   busy     out  1        state != IDLE
// BEHAVIOUR
//   Reset (async, immediate)
//     - state=IDLE; gnt0/gnt1/done0/done1/busy/result=0; pointer=0 (requester 0 preferred); count=0.
//     - Any in-flight transaction is discarded; no done is issued for it.
//   FSM: IDLE -> CALC -> DONE -> IDLE
//   IDLE
//     - req0/req1 are sampled only in this state.
//     - Exactly one req high: grant it.
//     - Both high: grant the requester named by pointer.
//     - At the edge: gnt_x<=1; opA<=a_x; opB<=b_x; count<=HOLD_CYCLES-1; state->CALC.
//   CALC
//     - Multiplier is driven only from opA/opB; requester operand changes after grant are ignored.
//     - Deassertion of req after grant is ignored; the transaction still completes.
//     - count!=0: count decrements each edge.
//     - count==0 at an edge: result<=opA*opB (full 2*WIDTH bits, no truncation); done_x<=1; state->DONE.
//   DONE
//     - Lasts exactly one cycle.
//     - Next edge: done_x<=0; gnt_x<=0; pointer<=other requester; state->IDLE.
//   Latency: req sampled at edge E0 -> gnt at E0 -> done/result at E0+HOLD_CYCLES -> IDLE at E0+HOLD_CYCLES+1.
//     Earliest next grant is at E0+HOLD_CYCLES+2.
//   Invariants
//     - gnt0 & gnt1 never both 1; done0 & done1 never both 1.
//     - done_x implies gnt_x.
//   Requester rule: a req still high in IDLE after its done is treated as a new request.
//   Fairness: pointer toggles only on completion, so two continuously held requests alternate 0,1,0,1...
//   Pointer update on a lone request: after serving requester 0 alone, pointer=1; an idle requester
//     never blocks the other.
// TESTING
//   1. Assert reset mid-sim with req0=1 -> every output 0 in the same timestep, without waiting for clk.
//   2. HOLD=1; req0=1, a0=3, b0=2 -> gnt0 at E0; done0=1 and result=4'b0110 at E1; idle at E2.
//   3. req0 (3*3) and req1 (2*3) rise together after reset -> req0 served first, result=9;
//      then req1, result=6; gnt0/gnt1 never overlap.
//   4. req0 and req1 held high for 6 transactions -> grant order 0,1,0,1,0,1; each done pulse exactly 1 cycle.
//   5. HOLD=3; a0=3, b0=3 granted, then a0 changed to 1 in CALC -> result=9 at E0+3; busy high for 4 cycles.
//   6. Sweep all 16 (a,b) pairs on each port -> result==a*b for every pair (0..9).
//      Assert reset during CALC, then req1 alone -> req1 served, no stale done0.

Source files
------------

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mult_share_arbiter: round-robin share of one combinational multiplier   |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+

module lab3_3_2 #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] out
);
   assign out = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
endmodule

module mult_share_arbiter #(
   parameter int WIDTH       = 2,
   parameter int HOLD_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0,
   input  logic [WIDTH-1:0]   a0,
   input  logic [WIDTH-1:0]   b0,
   input  logic               req1,
   input  logic [WIDTH-1:0]   a1,
   input  logic [WIDTH-1:0]   b1,
   output logic               gnt0,
   output logic               gnt1,
   output logic               done0,
   output logic               done1,
   output logic [2*WIDTH-1:0] result,
   output logic               busy
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // HOLD_CYCLES is legal in 1..15, so the reload value always fits 4 bits
   localparam logic [3:0] CNT_INIT = 4'(HOLD_CYCLES - 1);

   state_t               state_q;
   logic                 ptr_q;
   logic [3:0]           cnt_q;
   logic [WIDTH-1:0]     opa_q;
   logic [WIDTH-1:0]     opb_q;
   logic                 gnt0_q;
   logic                 gnt1_q;
   logic                 done0_q;
   logic                 done1_q;
   logic [2*WIDTH-1:0]   result_q;

   logic                 pick1_d;
   logic [WIDTH-1:0]     opa_d;
   logic [WIDTH-1:0]     opb_d;
   logic [2*WIDTH-1:0]   prod;

   // Requester 1 wins when alone, or when both ask and the pointer favours it
   assign pick1_d = req1 & (~req0 | ptr_q);
   assign opa_d   = pick1_d ? a1 : a0;
   assign opb_d   = pick1_d ? b1 : b0;

   lab3_3_2 #(.WIDTH(WIDTH)) u_mult (
      .a   (opa_q),
      .b   (opb_q),
      .out (prod)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         cnt_q    <= 4'd0;
         opa_q    <= '0;
         opb_q    <= '0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0 | req1) begin
                  gnt0_q  <= ~pick1_d;
                  gnt1_q  <= pick1_d;
                  opa_q   <= opa_d;
                  opb_q   <= opb_d;
                  cnt_q   <= CNT_INIT;
                  state_q <= CALC;
               end
            end
            CALC: begin
               if (cnt_q == 4'd0) begin
                  result_q <= prod;
                  done0_q  <= gnt0_q;
                  done1_q  <= gnt1_q;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            DONE: begin
               // Pointer moves to whoever was not just served
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               ptr_q   <= gnt0_q;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt0   = gnt0_q;
   assign gnt1   = gnt1_q;
   assign done0  = done0_q;
   assign done1  = done1_q;
   assign result = result_q;
   assign busy   = (state_q != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mult_share_arbiter: self-checking bench for mult_share_arbiter       |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module tb_mult_share_arbiter;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic       gnt0, gnt1, done0, done1, busy;
   logic [3:0] result;

   logic       q0_3 = 1'b0, q1_3 = 1'b0;
   logic [1:0] a0_3 = '0, b0_3 = '0, a1_3 = '0, b1_3 = '0;
   logic       gnt0_3, gnt1_3, done0_3, done1_3, busy3;
   logic [3:0] result3;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int         id;
      logic [3:0] res;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic       r0, r1;
      logic [1:0] a0, b0, a1, b1;
      int         id;
      logic [3:0] res;
   } vec_t;
   vec_t tbl[8];

   always #5 clk = ~clk;

   mult_share_arbiter #(.WIDTH(2), .HOLD_CYCLES(1)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .busy(busy)
   );

   mult_share_arbiter #(.WIDTH(2), .HOLD_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset),
      .req0(q0_3), .a0(a0_3), .b0(b0_3),
      .req1(q1_3), .a1(a1_3), .b1(b1_3),
      .gnt0(gnt0_3), .gnt1(gnt1_3), .done0(done0_3), .done1(done1_3),
      .result(result3), .busy(busy3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
      chk("done_exclusive", {31'd0, done0 & done1}, 32'd0);
      chk("done_implies_gnt", {30'd0, done1 & ~gnt1, done0 & ~gnt0}, 32'd0);
      chk("gnt3_exclusive", {31'd0, gnt0_3 & gnt1_3}, 32'd0);
   end

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!(done0 | done1) && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   // One transaction on the HOLD=1 instance; operands are scrambled after grant
   task automatic run_txn(input logic r0, input logic r1,
                          input logic [1:0] xa0, input logic [1:0] xb0,
                          input logic [1:0] xa1, input logic [1:0] xb1,
                          input int eid, input logic [3:0] eres);
      int   cyc;
      exp_t e;
      @(negedge clk);
      req0 = r0; req1 = r1; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
      sbq.push_back('{eid, eres});
      @(posedge clk); #1;
      chk("gnt", {30'd0, gnt1, gnt0}, (eid == 1) ? 32'd2 : 32'd1);
      chk("busy_calc", {31'd0, busy}, 32'd1);
      req0 = 1'b0; req1 = 1'b0; a0 = ~xa0; a1 = ~xa1;
      wait_done(cyc);
      chk("done_latency", cyc, 32'd1);
      e = sbq.pop_front();
      chk("done_id", {30'd0, done1, done0}, (e.id == 1) ? 32'd2 : 32'd1);
      chk("result", {28'd0, result}, {28'd0, e.res});
      @(posedge clk); #1;
      chk("idle_after", {27'd0, busy, gnt1, gnt0, done1, done0}, 32'd0);
      chk("result_hold", {28'd0, result}, {28'd0, e.res});
   endtask

   initial begin
      int   cyc;
      exp_t e;

      tbl[0] = '{1'b1, 1'b1, 2'd3, 2'd3, 2'd2, 2'd3, 0, 4'd9};
      tbl[1] = '{1'b1, 1'b1, 2'd3, 2'd3, 2'd2, 2'd3, 1, 4'd6};
      tbl[2] = '{1'b1, 1'b0, 2'd3, 2'd2, 2'd0, 2'd0, 0, 4'd6};
      tbl[3] = '{1'b1, 1'b0, 2'd1, 2'd1, 2'd0, 2'd0, 0, 4'd1};
      tbl[4] = '{1'b0, 1'b1, 2'd0, 2'd0, 2'd3, 2'd3, 1, 4'd9};
      tbl[5] = '{1'b0, 1'b1, 2'd0, 2'd0, 2'd2, 2'd2, 1, 4'd4};
      tbl[6] = '{1'b1, 1'b1, 2'd0, 2'd3, 2'd3, 2'd1, 0, 4'd0};
      tbl[7] = '{1'b1, 1'b1, 2'd0, 2'd3, 2'd3, 2'd1, 1, 4'd3};

      #2;
      chk("reset_outputs", {24'd0, result, busy, gnt1, gnt0, done1}, 32'd0);
      chk("reset_done0", {31'd0, done0}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      foreach (tbl[i])
         run_txn(tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].b0,
                 tbl[i].a1, tbl[i].b1, tbl[i].id, tbl[i].res);

      // Asynchronous reset mid-transaction clears every output immediately
      @(negedge clk);
      req0 = 1'b1; a0 = 2'd3; b0 = 2'd2;
      @(posedge clk); #3;
      chk("pre_reset_gnt0", {31'd0, gnt0}, 32'd1);
      reset = 1'b1;
      #1;
      chk("async_reset", {24'd0, result, busy, gnt1, gnt0, done1}, 32'd0);
      chk("async_reset_done0", {31'd0, done0}, 32'd0);
      req0 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("no_stale_done", {30'd0, done1, done0}, 32'd0);
      end

      // Both held continuously: strict alternation starting at requester 0
      @(negedge clk);
      req0 = 1'b1; req1 = 1'b1; a0 = 2'd1; b0 = 2'd2; a1 = 2'd3; b1 = 2'd3;
      for (int k = 0; k < 6; k++)
         sbq.push_back('{k % 2, (k % 2 == 1) ? 4'd9 : 4'd2});
      for (int k = 0; k < 6; k++) begin
         wait_done(cyc);
         if (k == 5) begin
            req0 = 1'b0; req1 = 1'b0;
         end
         chk("rr_latency", cyc, 32'd2);
         e = sbq.pop_front();
         chk("rr_order", {30'd0, done1, done0}, (e.id == 1) ? 32'd2 : 32'd1);
         chk("rr_result", {28'd0, result}, {28'd0, e.res});
         @(posedge clk); #1;
         chk("rr_done_pulse", {30'd0, done1, done0}, 32'd0);
      end
      @(posedge clk); #1;
      chk("rr_idle", {29'd0, busy, gnt1, gnt0}, 32'd0);

      // HOLD=3 instance: operand change during CALC must not affect result
      @(negedge clk);
      q0_3 = 1'b1; a0_3 = 2'd3; b0_3 = 2'd3;
      @(posedge clk); #1;
      chk("h3_gnt0", {31'd0, gnt0_3}, 32'd1);
      chk("h3_busy0", {31'd0, busy3}, 32'd1);
      a0_3 = 2'd1; q0_3 = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         chk("h3_busy", {31'd0, busy3}, 32'd1);
         chk("h3_done", {31'd0, done0_3}, (c == 3) ? 32'd1 : 32'd0);
      end
      chk("h3_result", {28'd0, result3}, 32'd9);
      @(posedge clk); #1;
      chk("h3_idle", {29'd0, busy3, gnt0_3, done0_3}, 32'd0);

      // Exhaustive operand sweep on each port
      for (int p = 0; p < 2; p++)
         for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
               run_txn(p == 0, p == 1, 2'(a), 2'(b), 2'(a), 2'(b), p, 4'(a * b));

      // Reset during CALC, then requester 1 alone
      @(negedge clk);
      req0 = 1'b1; a0 = 2'd3; b0 = 2'd3;
      @(posedge clk); #3;
      chk("calc_before_reset", {31'd0, busy}, 32'd1);
      reset = 1'b1; req0 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      run_txn(1'b0, 1'b1, 2'd0, 2'd0, 2'd2, 2'd2, 1, 4'd4);

      repeat (2) @(negedge clk);
      chk("queue_empty", sbq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
